sha_nonce_sched: RTL and testbench
==================================

SHA_NONCE_SCHED -- requirements
Module: sha_nonce_sched

Interface
REQ-001 The block SHALL have parameter DELAY, default 16: minimum cycles between issues, equal to the per-stage round count of the downstream pipeline.
REQ-002 The block SHALL have parameter MAX_INFLIGHT, default 64: maximum number of nonces issued but not yet returned.
REQ-003 The block SHALL have parameter H_SIZE, default 256: hash width.
REQ-004 The block SHALL have the following ports:
- clk  in  1  clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle job launch pulse.
- abort  in  1  one-cycle job cancel pulse.
- nonce_first  in  32  first nonce of the range, inclusive.
- nonce_last  in  32  last nonce of the range, inclusive.
- target  in  H_SIZE  hit threshold.
- issue_en  out  1  one-cycle pulse to the pipeline head enable.
- issue_nonce  out  32  nonce presented with issue_en.
- res_valid  in  1  pipeline tail result strobe.
- res_nonce  in  32  nonce of the returned result.
- res_hash  in  H_SIZE  hash of the returned result.
- busy  out  1  job active.
- done  out  1  job finished; held high until the next accepted start.
- found  out  1  a hit occurred in the finished job.
- found_nonce  out  32  nonce of the hit.
- inflight  out  7  current outstanding count.
- err  out  1  sticky protocol error.

Function
REQ-005 The FSM SHALL have the states IDLE, ISSUE, DRAIN and DONE; busy SHALL be 1 in ISSUE and DRAIN only.
REQ-006 In IDLE or DONE, start=1 SHALL sample nonce_first, nonce_last and target, clear done, found, found_nonce and err, and enter ISSUE.
REQ-007 start SHALL be ignored in ISSUE and DRAIN.
REQ-008 The job range SHALL wrap modulo 2^32, with count = ((nonce_last - nonce_first) mod 2^32) + 1; a 33-bit remaining counter SHALL support count 2^32 (nonce_last = nonce_first - 1).
REQ-009 The first issue_en SHALL occur the cycle after start is accepted, with issue_nonce = nonce_first.
REQ-010 Each subsequent issue SHALL occur exactly DELAY cycles after the previous one, with issue_nonce incremented by 1, wrapping 0xFFFFFFFF to 0.
REQ-011 issue_en SHALL never assert on two cycles closer than DELAY apart.
REQ-012 If an issue slot arrives while inflight == MAX_INFLIGHT, the issue SHALL be deferred to the first cycle with inflight < MAX_INFLIGHT, and DELAY spacing SHALL restart from that issue.
REQ-013 inflight SHALL be +1 on issue_en, -1 on accepted res_valid, and unchanged when both occur in the same cycle.
REQ-014 A result SHALL be a hit iff res_hash <= target (unsigned, H_SIZE bits).
REQ-015 The first hit of a job SHALL set found=1 and found_nonce=res_nonce.
REQ-016 Any later hit in the same job SHALL be counted but SHALL NOT overwrite found_nonce.
REQ-017 ISSUE SHALL go to DRAIN on the cycle after the last nonce is issued, on a hit, or on abort.
REQ-018 No issue_en SHALL assert in the cycle of the exit condition or afterwards.
REQ-019 If a hit and the final issue slot coincide in one cycle, the hit SHALL take priority and that issue SHALL be suppressed.
REQ-020 DRAIN SHALL go to DONE on the cycle inflight reaches 0; done SHALL assert on that transition.
REQ-021 abort in DRAIN SHALL have no further effect.
REQ-022 abort in IDLE or DONE SHALL be ignored.
REQ-023 res_valid with inflight == 0 SHALL set err=1, SHALL be otherwise ignored, and SHALL NOT underflow inflight.
REQ-024 issue_nonce SHALL hold its last value when issue_en=0.

Reset
REQ-025 On reset=0, asynchronously: state=IDLE, and issue_en, busy, done, found, err, inflight, found_nonce and issue_nonce SHALL all be 0.
REQ-026 The slot timer and the remaining counter SHALL be cleared on reset.
REQ-027 Reset mid-job SHALL abandon the job; results returning after reset release SHALL be treated per REQ-023.
REQ-028 Exiting reset SHALL require no start-up cycles: start SHALL be accepted on the first rising edge after release.

Verification
REQ-029 The bench SHALL cover: nonce_first=10, nonce_last=13, pipeline latency 40, no hits -> issues at t=1,17,33,49 with nonces 10..13; done once the 4th result returns; found=0; err=0.
REQ-030 The bench SHALL cover: range 0..99, target above the 3rd result hash only -> found_nonce=2; no issue after the hit cycle; done after inflight drains to 0.
REQ-031 The bench SHALL cover: nonce_first=0xFFFFFFFE, nonce_last=0x00000001 -> issued nonces FFFFFFFE, FFFFFFFF, 0, 1; count 4.
REQ-032 The bench SHALL cover: MAX_INFLIGHT=2, latency 100 -> 3rd issue deferred until the 1st result returns; spacing then DELAY from that issue.
REQ-033 The bench SHALL cover: abort during the 2nd slot gap of a 10-nonce job -> exactly 2 issued; done with found=0 after 2 results.
REQ-034 The bench SHALL cover: reset pulse mid-ISSUE with 3 in flight -> all outputs 0 immediately; 3 late res_valid pulses set err=1; a following start then clears err.

Source files
------------

// File: rtl/sha_nonce_sched.sv
// Nonce range scheduler for a DELAY-round hashing pipeline: issues nonces at a fixed
// cadence, bounds outstanding work, and stops the job on the first hash at or below target.
module sha_nonce_sched #(
    parameter int DELAY        = 16,
    parameter int MAX_INFLIGHT = 64,
    parameter int H_SIZE       = 256
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic [31:0]       nonce_first,
    input  logic [31:0]       nonce_last,
    input  logic [H_SIZE-1:0] target,
    output logic              issue_en,
    output logic [31:0]       issue_nonce,
    input  logic              res_valid,
    input  logic [31:0]       res_nonce,
    input  logic [H_SIZE-1:0] res_hash,
    output logic              busy,
    output logic              done,
    output logic              found,
    output logic [31:0]       found_nonce,
    output logic [6:0]        inflight,
    output logic              err
);

    localparam int TW = (DELAY > 1) ? $clog2(DELAY) : 1;

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

    state_t            state, state_d;
    logic [31:0]       nxt_nonce;
    logic [31:0]       last_nonce;
    logic [32:0]       remaining;
    logic [TW-1:0]     slot_timer;
    logic [H_SIZE-1:0] target_q;
    logic [6:0]        inflight_d;
    logic              active;
    logic              start_acc;
    logic              res_acc;
    logic              hit;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_d;
    end

    always_comb begin
        active    = (state == ISSUE) || (state == DRAIN);
        start_acc = start && ((state == IDLE) || (state == DONE));
        // A result with nothing outstanding is a protocol error and is otherwise dropped.
        res_acc   = res_valid && (inflight != 7'd0);
        hit       = res_acc && active && (res_hash <= target_q);
        // A hit or abort in the slot cycle wins over the issue.
        issue_en  = (state == ISSUE) && (slot_timer == '0) && (remaining != 33'd0) &&
                    (inflight < 7'(MAX_INFLIGHT)) && !abort && !hit;

        inflight_d = inflight;
        if (issue_en && !res_acc)      inflight_d = inflight + 7'd1;
        else if (!issue_en && res_acc) inflight_d = inflight - 7'd1;

        state_d = state;
        case (state)
            IDLE, DONE: if (start_acc) state_d = ISSUE;
            ISSUE:      if (hit || abort || (issue_en && remaining == 33'd1)) state_d = DRAIN;
            DRAIN:      if (inflight_d == 7'd0) state_d = DONE;
            default:    state_d = IDLE;
        endcase

        busy        = active;
        done        = (state == DONE);
        issue_nonce = issue_en ? nxt_nonce : last_nonce;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            nxt_nonce   <= '0;
            last_nonce  <= '0;
            remaining   <= '0;
            slot_timer  <= '0;
            target_q    <= '0;
            inflight    <= '0;
            found       <= 1'b0;
            found_nonce <= '0;
            err         <= 1'b0;
        end else begin
            inflight <= inflight_d;
            if (start_acc) begin
                nxt_nonce   <= nonce_first;
                // 33 bits so that a full wrap (last = first - 1) counts 2^32 nonces.
                remaining   <= {1'b0, nonce_last - nonce_first} + 33'd1;
                slot_timer  <= '0;
                target_q    <= target;
                found       <= 1'b0;
                found_nonce <= '0;
                err         <= 1'b0;
            end else begin
                if (issue_en) begin
                    nxt_nonce  <= nxt_nonce + 32'd1;
                    last_nonce <= nxt_nonce;
                    remaining  <= remaining - 33'd1;
                    slot_timer <= TW'(DELAY - 1);
                end else if (slot_timer != '0) begin
                    slot_timer <= slot_timer - 1'b1;
                end
                if (hit && !found) begin
                    found       <= 1'b1;
                    found_nonce <= res_nonce;
                end
                if (res_valid && inflight == 7'd0) err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_sha_nonce_sched.sv
// Directed bench for sha_nonce_sched: the bench models the hashing pipeline as a fixed
// latency FIFO and checks issue timing, hit handling, backpressure, abort and reset.
module tb_sha_nonce_sched;

    typedef struct {
        logic [31:0] nonce;
        int          due;
    } pkt_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [1:0]   start = 2'b00;
    logic [1:0]   abort = 2'b00;
    logic [31:0]  nonce_first = '0;
    logic [31:0]  nonce_last = '0;
    logic [255:0] target = '0;

    logic         issue_en_o    [2];
    logic [31:0]  issue_nonce_o [2];
    logic         busy_o        [2];
    logic         done_o        [2];
    logic         found_o       [2];
    logic [31:0]  found_nonce_o [2];
    logic [6:0]   inflight_o    [2];
    logic         err_o         [2];

    int           cyc = 0;
    int           lat = 40;
    bit           hit_en = 1'b0;
    logic [31:0]  hit_nonce = '0;
    int           nvec = 0;
    int           nmiss = 0;

    int           n_iss;
    int           iss_cyc [16];
    logic [31:0]  iss_non [16];
    int           done_cyc;
    int           infl_tr [300];
    logic         busy_s, found_s, err_s;
    logic [31:0]  fnonce_s, nonce_s;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [255:0] hash_of(input logic [31:0] n);
        if (hit_en && n == hit_nonce) return 256'd5;
        return ~{224'd0, n};
    endfunction

    for (genvar g = 0; g < 2; g++) begin : g_dut
        logic         res_valid;
        logic [31:0]  res_nonce;
        logic [255:0] res_hash;
        pkt_t         pq[$];

        sha_nonce_sched #(.DELAY(16), .MAX_INFLIGHT(g == 0 ? 64 : 2), .H_SIZE(256)) u_dut (
            .clk(clk), .reset(rst_n), .start(start[g]), .abort(abort[g]),
            .nonce_first(nonce_first), .nonce_last(nonce_last), .target(target),
            .issue_en(issue_en_o[g]), .issue_nonce(issue_nonce_o[g]),
            .res_valid(res_valid), .res_nonce(res_nonce), .res_hash(res_hash),
            .busy(busy_o[g]), .done(done_o[g]), .found(found_o[g]),
            .found_nonce(found_nonce_o[g]), .inflight(inflight_o[g]), .err(err_o[g]));

        always @(negedge clk)
            if (issue_en_o[g]) pq.push_back('{issue_nonce_o[g], cyc + lat});

        always @(posedge clk) begin
            #1;
            if (pq.size() > 0 && pq[0].due == cyc) begin
                res_valid = 1'b1;
                res_nonce = pq[0].nonce;
                res_hash  = hash_of(pq[0].nonce);
                void'(pq.pop_front());
            end else begin
                res_valid = 1'b0;
                res_nonce = '0;
                res_hash  = '0;
            end
        end
    end

    task automatic launch(input int sel, input logic [31:0] f, input logic [31:0] l,
                          input logic [255:0] t);
        @(posedge clk); #1;
        nonce_first = f;
        nonce_last  = l;
        target      = t;
        start[sel]  = 1'b1;
    endtask

    // Runs cycles 1..budget after a launch, recording issues and stopping at done.
    task automatic mon(input int sel, input int abort_at, input int budget);
        n_iss    = 0;
        done_cyc = -1;
        for (int k = 1; k <= budget; k++) begin
            @(posedge clk); #1;
            start[sel] = 1'b0;
            abort[sel] = (k == abort_at);
            @(negedge clk);
            if (k < 300) infl_tr[k] = int'(inflight_o[sel]);
            if (issue_en_o[sel]) begin
                if (n_iss < 16) begin
                    iss_cyc[n_iss] = k;
                    iss_non[n_iss] = issue_nonce_o[sel];
                end
                n_iss++;
            end
            if (done_o[sel]) begin
                done_cyc = k;
                break;
            end
        end
        abort[sel] = 1'b0;
        busy_s   = busy_o[sel];
        found_s  = found_o[sel];
        fnonce_s = found_nonce_o[sel];
        err_s    = err_o[sel];
        nonce_s  = issue_nonce_o[sel];
    endtask

    task automatic test_reset();
        #2;
        nvec++; if (issue_en_o[0] !== 1'b0) begin nmiss++; $display("FAIL rst_issue_en: got %b want 0", issue_en_o[0]); end
        nvec++; if (busy_o[0] !== 1'b0) begin nmiss++; $display("FAIL rst_busy: got %b want 0", busy_o[0]); end
        nvec++; if (done_o[0] !== 1'b0) begin nmiss++; $display("FAIL rst_done: got %b want 0", done_o[0]); end
        nvec++; if (found_o[0] !== 1'b0) begin nmiss++; $display("FAIL rst_found: got %b want 0", found_o[0]); end
        nvec++; if (err_o[0] !== 1'b0) begin nmiss++; $display("FAIL rst_err: got %b want 0", err_o[0]); end
        nvec++; if (inflight_o[0] !== 7'd0) begin nmiss++; $display("FAIL rst_inflight: got %0d want 0", inflight_o[0]); end
        nvec++; if (issue_nonce_o[0] !== 32'd0) begin nmiss++; $display("FAIL rst_issue_nonce: got %h want 0", issue_nonce_o[0]); end
        // Start asserted in the same cycle reset releases must be taken at the next edge.
        lat = 40; hit_en = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        nonce_first = 32'd5; nonce_last = 32'd5; target = '0;
        start[0] = 1'b1;
        mon(0, 0, 60);
        nvec++; if (n_iss !== 1) begin nmiss++; $display("FAIL rel_n_iss: got %0d want 1", n_iss); end
        nvec++; if (iss_cyc[0] !== 1) begin nmiss++; $display("FAIL rel_first_cyc: got %0d want 1", iss_cyc[0]); end
        nvec++; if (iss_non[0] !== 32'd5) begin nmiss++; $display("FAIL rel_nonce: got %h want 5", iss_non[0]); end
        nvec++; if (done_cyc !== 42) begin nmiss++; $display("FAIL rel_done_cyc: got %0d want 42", done_cyc); end
    endtask

    task automatic test_basic();
        int exp_c[4] = '{1, 17, 33, 49};
        lat = 40; hit_en = 1'b0;
        launch(0, 32'd10, 32'd13, '0);
        mon(0, 0, 150);
        nvec++; if (n_iss !== 4) begin nmiss++; $display("FAIL basic_n_iss: got %0d want 4", n_iss); end
        for (int i = 0; i < 4; i++) begin
            nvec++; if (iss_cyc[i] !== exp_c[i]) begin nmiss++; $display("FAIL basic_cyc%0d: got %0d want %0d", i, iss_cyc[i], exp_c[i]); end
            nvec++; if (iss_non[i] !== 32'(10 + i)) begin nmiss++; $display("FAIL basic_nonce%0d: got %h want %h", i, iss_non[i], 32'(10 + i)); end
        end
        nvec++; if (infl_tr[40] !== 3) begin nmiss++; $display("FAIL basic_infl40: got %0d want 3", infl_tr[40]); end
        nvec++; if (infl_tr[42] !== 2) begin nmiss++; $display("FAIL basic_infl42: got %0d want 2", infl_tr[42]); end
        nvec++; if (done_cyc !== 90) begin nmiss++; $display("FAIL basic_done_cyc: got %0d want 90", done_cyc); end
        nvec++; if (busy_s !== 1'b0) begin nmiss++; $display("FAIL basic_busy: got %b want 0", busy_s); end
        nvec++; if (found_s !== 1'b0) begin nmiss++; $display("FAIL basic_found: got %b want 0", found_s); end
        nvec++; if (err_s !== 1'b0) begin nmiss++; $display("FAIL basic_err: got %b want 0", err_s); end
        nvec++; if (nonce_s !== 32'd13) begin nmiss++; $display("FAIL basic_hold_nonce: got %h want d", nonce_s); end
    endtask

    task automatic test_hit();
        lat = 40; hit_en = 1'b1; hit_nonce = 32'd2;
        launch(0, 32'd0, 32'd99, 256'd100);
        mon(0, 0, 200);
        nvec++; if (n_iss !== 5) begin nmiss++; $display("FAIL hit_n_iss: got %0d want 5", n_iss); end
        nvec++; if (iss_cyc[4] !== 65) begin nmiss++; $display("FAIL hit_last_cyc: got %0d want 65", iss_cyc[4]); end
        nvec++; if (infl_tr[74] !== 2) begin nmiss++; $display("FAIL hit_infl74: got %0d want 2", infl_tr[74]); end
        nvec++; if (done_cyc !== 106) begin nmiss++; $display("FAIL hit_done_cyc: got %0d want 106", done_cyc); end
        nvec++; if (found_s !== 1'b1) begin nmiss++; $display("FAIL hit_found: got %b want 1", found_s); end
        nvec++; if (fnonce_s !== 32'd2) begin nmiss++; $display("FAIL hit_found_nonce: got %h want 2", fnonce_s); end
        hit_en = 1'b0;
    endtask

    task automatic test_hit_slot();
        lat = 32; hit_en = 1'b1; hit_nonce = 32'd0;
        launch(0, 32'd0, 32'd9, 256'd100);
        mon(0, 0, 120);
        nvec++; if (n_iss !== 2) begin nmiss++; $display("FAIL slot_n_iss: got %0d want 2", n_iss); end
        nvec++; if (done_cyc !== 50) begin nmiss++; $display("FAIL slot_done_cyc: got %0d want 50", done_cyc); end
        nvec++; if (fnonce_s !== 32'd0 || found_s !== 1'b1) begin nmiss++; $display("FAIL slot_found: got %b/%h want 1/0", found_s, fnonce_s); end
        hit_en = 1'b0;
    endtask

    task automatic test_wrap();
        logic [31:0] exp_n[4] = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0, 32'h1};
        lat = 40; hit_en = 1'b0;
        launch(0, 32'hFFFF_FFFE, 32'h0000_0001, '0);
        mon(0, 0, 150);
        nvec++; if (n_iss !== 4) begin nmiss++; $display("FAIL wrap_n_iss: got %0d want 4", n_iss); end
        for (int i = 0; i < 4; i++) begin
            nvec++; if (iss_non[i] !== exp_n[i]) begin nmiss++; $display("FAIL wrap_nonce%0d: got %h want %h", i, iss_non[i], exp_n[i]); end
        end
        nvec++; if (done_cyc !== 90) begin nmiss++; $display("FAIL wrap_done_cyc: got %0d want 90", done_cyc); end
    endtask

    task automatic test_backpressure();
        int exp_c[4] = '{1, 17, 102, 118};
        lat = 100; hit_en = 1'b0;
        launch(1, 32'd0, 32'd3, '0);
        mon(1, 0, 260);
        nvec++; if (n_iss !== 4) begin nmiss++; $display("FAIL bp_n_iss: got %0d want 4", n_iss); end
        for (int i = 0; i < 4; i++) begin
            nvec++; if (iss_cyc[i] !== exp_c[i]) begin nmiss++; $display("FAIL bp_cyc%0d: got %0d want %0d", i, iss_cyc[i], exp_c[i]); end
        end
        nvec++; if (infl_tr[50] !== 2) begin nmiss++; $display("FAIL bp_infl50: got %0d want 2", infl_tr[50]); end
        nvec++; if (infl_tr[102] !== 1) begin nmiss++; $display("FAIL bp_infl102: got %0d want 1", infl_tr[102]); end
        nvec++; if (done_cyc !== 219) begin nmiss++; $display("FAIL bp_done_cyc: got %0d want 219", done_cyc); end
    endtask

    task automatic test_abort();
        lat = 40; hit_en = 1'b0;
        launch(0, 32'd0, 32'd9, '0);
        mon(0, 25, 150);
        nvec++; if (n_iss !== 2) begin nmiss++; $display("FAIL abort_n_iss: got %0d want 2", n_iss); end
        nvec++; if (done_cyc !== 58) begin nmiss++; $display("FAIL abort_done_cyc: got %0d want 58", done_cyc); end
        nvec++; if (found_s !== 1'b0) begin nmiss++; $display("FAIL abort_found: got %b want 0", found_s); end
    endtask

    task automatic test_reset_mid();
        lat = 40; hit_en = 1'b0;
        launch(0, 32'd0, 32'd9, '0);
        for (int k = 1; k <= 80; k++) begin
            @(posedge clk); #1;
            start[0] = 1'b0;
            if (k == 36) rst_n = 1'b0;
            if (k == 38) rst_n = 1'b1;
            if (k == 36) begin
                #1;
                nvec++; if (busy_o[0] !== 1'b0) begin nmiss++; $display("FAIL mid_busy: got %b want 0", busy_o[0]); end
                nvec++; if (inflight_o[0] !== 7'd0) begin nmiss++; $display("FAIL mid_inflight: got %0d want 0", inflight_o[0]); end
                nvec++; if (issue_nonce_o[0] !== 32'd0) begin nmiss++; $display("FAIL mid_issue_nonce: got %h want 0", issue_nonce_o[0]); end
                nvec++; if (issue_en_o[0] !== 1'b0 || done_o[0] !== 1'b0 || found_o[0] !== 1'b0 || err_o[0] !== 1'b0 || found_nonce_o[0] !== 32'd0)
                    begin nmiss++; $display("FAIL mid_flags: got %b%b%b%b/%h want 0000/0", issue_en_o[0], done_o[0], found_o[0], err_o[0], found_nonce_o[0]); end
            end
            @(negedge clk);
            if (k == 35) begin
                nvec++; if (inflight_o[0] !== 7'd3) begin nmiss++; $display("FAIL mid_pre_infl: got %0d want 3", inflight_o[0]); end
            end
            if (k == 40) begin
                nvec++; if (err_o[0] !== 1'b0) begin nmiss++; $display("FAIL mid_err40: got %b want 0", err_o[0]); end
            end
        end
        nvec++; if (err_o[0] !== 1'b1) begin nmiss++; $display("FAIL mid_err_late: got %b want 1", err_o[0]); end
        nvec++; if (inflight_o[0] !== 7'd0) begin nmiss++; $display("FAIL mid_no_underflow: got %0d want 0", inflight_o[0]); end
        launch(0, 32'd7, 32'd7, '0);
        mon(0, 0, 60);
        nvec++; if (err_s !== 1'b0) begin nmiss++; $display("FAIL mid_err_clear: got %b want 0", err_s); end
        nvec++; if (n_iss !== 1 || iss_non[0] !== 32'd7) begin nmiss++; $display("FAIL mid_restart: got %0d/%h want 1/7", n_iss, iss_non[0]); end
        nvec++; if (done_cyc !== 42) begin nmiss++; $display("FAIL mid_done_cyc: got %0d want 42", done_cyc); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_hit();
        test_hit_slot();
        test_wrap();
        test_backpressure();
        test_abort();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmiss);
        $finish;
    end

endmodule
